// File: rtl/config_pkg.sv
// Shared types and constants for the configuration bitstream loader.
package config_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StDone,
    StError
  } state_e;

  // CRC-16-CCITT generator, non-reflected.
  localparam logic [15:0] CRC_POLY = 16'h1021;

  // Default fabric configuration chain length in bits.
  localparam int unsigned DEFAULT_BITS = 4480;

  // Width of the bit and word counters (covers chains up to 8191 bits).
  localparam int unsigned CNT_W = 13;

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16 (MSB-first shift, no reflection, no final XOR).
// Kept standalone so the readback checker can reuse it.
module crc16_serial
  import config_pkg::*;
#(
  parameter logic [15:0] Init = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  // Next CRC: clear has priority over an update.
  always_comb begin
    crc_d = crc_q;
    fb    = bit_i ^ crc_q[15];
    if (clear_i) begin
      crc_d = Init;
    end else if (en_i) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
  end

  // CRC state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= Init;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/config_loader.sv
// Streams 32-bit bitstream words LSB-first into the fabric configuration
// chain and checks a trailing CRC-16 word against the shifted bits.
module config_loader
  import config_pkg::*;
#(
  parameter int unsigned BITS     = DEFAULT_BITS,
  parameter int unsigned WORD     = 32,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic              prog_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD-1:0]   s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              prog_in,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int unsigned ShW = $clog2(WORD + 1);
  localparam logic [CNT_W-1:0] NumWords = CNT_W'(BITS / WORD);
  localparam logic [CNT_W-1:0] LastBit  = CNT_W'(BITS - 1);
  localparam logic [ShW-1:0]   FullCnt  = ShW'(WORD);

  state_e             state_q, state_d;
  logic [WORD-1:0]    hold_q, hold_d;
  logic               hold_vld_q, hold_vld_d;
  logic [WORD-1:0]    shift_q, shift_d;
  logic [ShW-1:0]     sh_cnt_q, sh_cnt_d;    // bits still to shift out
  logic [CNT_W-1:0]   words_q, words_d;      // words accepted this load
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               prog_in_q, prog_in_d;
  logic               prog_en_q, prog_en_d;

  logic               shifting;
  logic               crc_clr, crc_en;
  logic [15:0]        crc;

  crc16_serial #(
    .Init (CRC_INIT)
  ) u_crc (
    .clk_i   (prog_clk),
    .rst_ni  (rst_n),
    .clear_i (crc_clr),
    .en_i    (crc_en),
    .bit_i   (shift_q[0]),
    .crc_o   (crc)
  );

  assign shifting = (sh_cnt_q != '0);

  // Next-state, buffer movement, serial output and stream handshake.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    sh_cnt_d   = sh_cnt_q;
    words_d    = words_q;
    bit_cnt_d  = bit_cnt_q;
    prog_in_d  = 1'b0;
    prog_en_d  = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    s_ready    = 1'b0;

    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d    = StLoad;
          crc_clr    = 1'b1;
          bit_cnt_d  = '0;
          words_d    = '0;
          hold_vld_d = 1'b0;
          sh_cnt_d   = '0;
        end
      end

      StLoad: begin
        s_ready = !hold_vld_q && (words_q < NumWords);
        if (shifting) begin
          prog_in_d = shift_q[0];
          prog_en_d = 1'b1;
          crc_en    = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          shift_d   = shift_q >> 1;
          sh_cnt_d  = sh_cnt_q - 1'b1;
          if (bit_cnt_q == LastBit) begin
            state_d = StCheck;
          end
        end
        // Refill on the same edge the last bit leaves, so a full stream has no gaps.
        if ((!shifting || sh_cnt_q == ShW'(1)) && hold_vld_q) begin
          shift_d    = hold_q;
          sh_cnt_d   = FullCnt;
          hold_vld_d = 1'b0;
        end
        if (s_valid && s_ready) begin
          hold_d     = s_data;
          hold_vld_d = 1'b1;
          words_d    = words_q + 1'b1;
        end
      end

      StCheck: begin
        s_ready = 1'b1;
        if (s_valid) begin
          state_d = (s_data[15:0] == crc) ? StDone : StError;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything, including a simultaneous start.
    if (abort) begin
      state_d   = StIdle;
      prog_in_d = 1'b0;
      prog_en_d = 1'b0;
    end
  end

  // State, buffers, counters and registered chain outputs.
  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      shift_q    <= '0;
      sh_cnt_q   <= '0;
      words_q    <= '0;
      bit_cnt_q  <= '0;
      prog_in_q  <= 1'b0;
      prog_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      shift_q    <= shift_d;
      sh_cnt_q   <= sh_cnt_d;
      words_q    <= words_d;
      bit_cnt_q  <= bit_cnt_d;
      prog_in_q  <= prog_in_d;
      prog_en_q  <= prog_en_d;
    end
  end

  assign prog_in   = prog_in_q;
  assign prog_en   = prog_en_q;
  assign busy      = (state_q == StLoad) || (state_q == StCheck);
  assign done      = (state_q == StDone);
  assign error     = (state_q == StError);
  assign bit_count = bit_cnt_q;

endmodule
